// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder: write-only I2C register responder; optional 10x9 register file under I2C_RESP_REGFILE_EN
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR = 7'b0011010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SDCLK,
  inout  wire        SDAT,
  output logic       wrValid,
  output logic [6:0] wrRegister,
  output logic [8:0] wrData,
  output logic       busy,
  output logic [7:0] nackCount
`ifdef I2C_RESP_REGFILE_EN
  ,
  input  logic [3:0] rdAddr,
  output logic [8:0] rdData
`endif
);
  typedef enum logic [2:0] {IDLE, ADDR, ACK_ADDR, REG, ACK_REG, DATA, ACK_DATA, WAIT_STOP} state_t;
  state_t state_q, state_d;
  logic [1:0] scl_q, sda_q;
  logic scl_p_q, sda_p_q;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] sh_q, sh_d;
  logic [7:0] reg_q, reg_d;
  logic ph_q, ph_d, ack_q, ack_d, drv_q, drv_d, wv_q, wv_d;
  logic [6:0] wreg_q, wreg_d;
  logic [8:0] wdat_q, wdat_d;
  logic [7:0] nack_q, nack_d, nack_inc;
  logic scl, sda, rise, fall, start, stop, last;
  logic [7:0] nbyte;
  assign scl = scl_q[1];
  assign sda = sda_q[1];
  assign rise = scl & ~scl_p_q;
  assign fall = ~scl & scl_p_q;
  assign start = scl & scl_p_q & sda_p_q & ~sda;
  assign stop = scl & scl_p_q & ~sda_p_q & sda;
  assign nbyte = {sh_q, sda};
  assign last = rise && cnt_q == 4'd7;
  assign nack_inc = nack_q + {7'd0, nack_q != 8'hFF};
  assign SDAT = drv_q ? 1'b0 : 1'bz;
  assign wrValid = wv_q;
  assign wrRegister = wreg_q;
  assign wrData = wdat_q;
  assign busy = state_q != IDLE;
  assign nackCount = nack_q;
  // Bus decode: STOP/START override everything, otherwise shift bits and run the ACK handshake
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    reg_d = reg_q;
    ph_d = ph_q;
    ack_d = ack_q;
    drv_d = drv_q;
    wv_d = 1'b0;
    wreg_d = wreg_q;
    wdat_d = wdat_q;
    nack_d = nack_q;
    if (stop) begin
      state_d = IDLE;
      drv_d = 1'b0;
    end else if (start) begin
      state_d = ADDR;
      cnt_d = 4'd0;
      drv_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, REG, DATA: if (rise) begin
          sh_d = nbyte[6:0];
          cnt_d = last ? 4'd0 : cnt_q + 4'd1;
          ph_d = 1'b0;
          if (last && state_q == ADDR) begin
            ack_d = nbyte == {DEV_ADDR, 1'b0};
            nack_d = ack_d ? nack_q : nack_inc;
            state_d = ACK_ADDR;
          end else if (last && state_q == REG) begin
            reg_d = nbyte;
            ack_d = 1'b1;
            state_d = ACK_REG;
          end else if (last) begin
            ack_d = 1'b1;
            wv_d = 1'b1;
            wreg_d = reg_q[7:1];
            wdat_d = {reg_q[0], nbyte};
            state_d = ACK_DATA;
          end
        end
        ACK_ADDR, ACK_REG, ACK_DATA: if (fall) begin
          ph_d = 1'b1;
          drv_d = ~ph_q & ack_q;
          if (ph_q)
            state_d = state_q == ACK_REG ? DATA : (state_q == ACK_ADDR && ack_q) ? REG : WAIT_STOP;
        end
        WAIT_STOP: if (rise) begin
          cnt_d = cnt_q == 4'd8 ? 4'd0 : cnt_q + 4'd1;
          nack_d = cnt_q == 4'd7 ? nack_inc : nack_q;
        end
        default: ;
      endcase
    end
  end
  // State, synchronizers and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_q <= 2'b11;
      sda_q <= 2'b11;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      reg_q <= '0;
      ph_q <= 1'b0;
      ack_q <= 1'b0;
      drv_q <= 1'b0;
      wv_q <= 1'b0;
      wreg_q <= '0;
      wdat_q <= '0;
      nack_q <= '0;
    end else begin
      scl_q <= {scl_q[0], SDCLK};
      sda_q <= {sda_q[0], SDAT};
      scl_p_q <= scl;
      sda_p_q <= sda;
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      reg_q <= reg_d;
      ph_q <= ph_d;
      ack_q <= ack_d;
      drv_q <= drv_d;
      wv_q <= wv_d;
      wreg_q <= wreg_d;
      wdat_q <= wdat_d;
      nack_q <= nack_d;
    end
  end
`ifdef I2C_RESP_REGFILE_EN
  logic [8:0] file_q [10];
  assign rdData = rdAddr < 4'd10 ? file_q[rdAddr] : 9'd0;
  // Register file updates alongside the strobe; register 15 clears the whole file
  always_ff @(posedge clk) begin
    if (!rst || (wv_d && wreg_d == 7'd15)) begin
      for (int i = 0; i < 10; i++) file_q[i] <= '0;
    end else if (wv_d && wreg_d < 7'd10) begin
      file_q[wreg_d[3:0]] <= wdat_d;
    end
  end
`endif
endmodule

// File: tb/tb_i2c_codec_responder.sv
// tb_i2c_codec_responder: directed bit-banged I2C master checking the responder
module tb_i2c_codec_responder;
  localparam int P = 5;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  wire SDAT;
  logic wrValid, busy;
  logic [6:0] wrRegister;
  logic [8:0] wrData;
  logic [7:0] nackCount;
  int n_vec = 0;
  int n_err = 0;
  int pulses = 0;
  int lowcnt = 0;
  logic [6:0] cap_reg = '0;
  logic [8:0] cap_dat = '0;
  logic a0, a1, a2;
`ifdef I2C_RESP_REGFILE_EN
  logic [3:0] rdAddr = '0;
  logic [8:0] rdData;
`endif
  pullup (SDAT);
  assign SDAT = m_sda ? 1'bz : 1'b0;
  always #5 clk = ~clk;
  i2c_codec_responder dut (
    .clk(clk),
    .rst(rst),
    .SDCLK(m_scl),
    .SDAT(SDAT),
    .wrValid(wrValid),
    .wrRegister(wrRegister),
    .wrData(wrData),
    .busy(busy),
    .nackCount(nackCount)
`ifdef I2C_RESP_REGFILE_EN
    ,
    .rdAddr(rdAddr),
    .rdData(rdData)
`endif
  );
  always @(negedge clk) begin
    if (wrValid) begin
      pulses++;
      cap_reg = wrRegister;
      cap_dat = wrData;
    end
    if (m_sda && SDAT === 1'b0) lowcnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic hold();
    repeat (P) @(negedge clk);
  endtask
  task automatic i2c_start();
    m_sda = 1'b1; hold();
    m_scl = 1'b1; hold();
    m_sda = 1'b0; hold();
    m_scl = 1'b0; hold();
  endtask
  task automatic i2c_stop();
    m_sda = 1'b0; hold();
    m_scl = 1'b1; hold();
    m_sda = 1'b1; hold();
  endtask
  task automatic i2c_bit(input logic b);
    m_sda = b; hold();
    m_scl = 1'b1; hold();
    m_scl = 1'b0; hold();
  endtask
  task automatic i2c_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
    m_sda = 1'b1; hold();
    m_scl = 1'b1; hold();
    ack = SDAT === 1'b0;
    m_scl = 1'b0; hold();
  endtask
  initial begin
    repeat (4) @(negedge clk);
    chk("rst_wrValid", wrValid, 0);
    chk("rst_wrRegister", wrRegister, 0);
    chk("rst_wrData", wrData, 0);
    chk("rst_busy", busy, 0);
    chk("rst_nack", nackCount, 0);
    chk("rst_sdat", SDAT, 1);
    rst = 1'b1;
    hold();
    i2c_start();
    chk("start_busy", busy, 1);
    i2c_byte(8'h34, a0);
    i2c_byte(8'h0C, a1);
    i2c_byte(8'h10, a2);
    chk("w1_ack_addr", a0, 1);
    chk("w1_ack_reg", a1, 1);
    chk("w1_ack_data", a2, 1);
    chk("w1_released", SDAT, 1);
    chk("w1_pulses", pulses, 1);
    chk("w1_reg", cap_reg, 7'h06);
    chk("w1_data", cap_dat, 9'h010);
    chk("w1_hold_reg", wrRegister, 7'h06);
    i2c_stop();
    chk("w1_busy_stop", busy, 0);
    lowcnt = 0;
    i2c_start();
    i2c_byte(8'h36, a0);
    chk("badaddr_ack", a0, 0);
    chk("badaddr_lowcnt", lowcnt, 0);
    chk("badaddr_nack", nackCount, 1);
    i2c_byte(8'h0C, a0);
    chk("waitstop_ack", a0, 0);
    chk("waitstop_nack", nackCount, 2);
    i2c_stop();
    chk("badaddr_pulses", pulses, 1);
    i2c_start();
    i2c_byte(8'h35, a0);
    chk("read_ack", a0, 0);
    chk("read_nack", nackCount, 3);
    i2c_stop();
    chk("read_idle", busy, 0);
    i2c_start();
    i2c_byte(8'h34, a0);
    i2c_byte(8'h0E, a1);
    i2c_stop();
    chk("partial_pulses", pulses, 1);
    i2c_start();
    i2c_byte(8'h34, a0);
    i2c_byte(8'h0E, a1);
    i2c_byte(8'h13, a2);
    chk("w2_pulses", pulses, 2);
    chk("w2_reg", cap_reg, 7'h07);
    chk("w2_data", cap_dat, 9'h013);
    i2c_byte(8'h55, a0);
    chk("w2_extra_ack", a0, 0);
    chk("w2_extra_nack", nackCount, 4);
    chk("w2_extra_pulses", pulses, 2);
    i2c_stop();
    i2c_start();
    i2c_byte(8'h34, a0);
    i2c_byte(8'h0C, a1);
    i2c_start();
    i2c_byte(8'h34, a0);
    i2c_byte(8'h0B, a1);
    i2c_byte(8'h55, a2);
    chk("rs_ack", {a0, a1, a2}, 3'b111);
    chk("rs_pulses", pulses, 3);
    chk("rs_reg", cap_reg, 7'h05);
    chk("rs_data", cap_dat, 9'h155);
    i2c_stop();
`ifdef I2C_RESP_REGFILE_EN
    i2c_start();
    i2c_byte(8'h34, a0);
    i2c_byte(8'h08, a1);
    i2c_byte(8'h10, a2);
    i2c_stop();
    rdAddr = 4'd4;
    @(negedge clk);
    chk("rf_rd4", rdData, 9'h010);
    rdAddr = 4'd5;
    @(negedge clk);
    chk("rf_rd5", rdData, 9'h155);
    rdAddr = 4'd12;
    @(negedge clk);
    chk("rf_rd12", rdData, 9'h000);
    i2c_start();
    i2c_byte(8'h34, a0);
    i2c_byte(8'h1E, a1);
    i2c_byte(8'h00, a2);
    i2c_stop();
    rdAddr = 4'd4;
    @(negedge clk);
    chk("rf_clr4", rdData, 9'h000);
    chk("rf_clr_reg", cap_reg, 7'd15);
`endif
    i2c_start();
    i2c_byte(8'h34, a0);
    i2c_byte(8'h0C, a1);
    for (int i = 0; i < 4; i++) i2c_bit(1'b1);
    m_sda = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_wrValid", wrValid, 0);
    chk("mid_wrRegister", wrRegister, 0);
    chk("mid_wrData", wrData, 0);
    chk("mid_busy", busy, 0);
    chk("mid_nack", nackCount, 0);
    chk("mid_sdat", SDAT, 1);
    pulses = 0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) i2c_bit(1'b0);
    i2c_bit(1'b1);
    chk("mid_no_pulse", pulses, 0);
    chk("mid_idle", busy, 0);
    i2c_stop();
    i2c_start();
    i2c_byte(8'h34, a0);
    i2c_byte(8'h0C, a1);
    i2c_byte(8'h10, a2);
    chk("post_ack", {a0, a1, a2}, 3'b111);
    chk("post_pulses", pulses, 1);
    chk("post_reg", cap_reg, 7'h06);
    chk("post_data", cap_dat, 9'h010);
    i2c_stop();
    i2c_start();
    i2c_byte(8'h36, a0);
    for (int i = 0; i < 254; i++) i2c_byte(8'h00, a0);
    chk("sat_ff", nackCount, 8'hFF);
    i2c_byte(8'h00, a0);
    chk("sat_hold", nackCount, 8'hFF);
    i2c_stop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_codec_responder.md
I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'b0011010, the 7-bit I2C device address this block answers to.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port SDCLK  input  1  I2C clock from the master, asynchronous to clk.
REQ-005 SHALL have port SDAT  inout  1  I2C data, open-drain; the block drives only 1'b0 or high-Z.
REQ-006 SHALL have port wrValid  output  1  one-clk pulse per completed, ACKed register write.
REQ-007 SHALL have port wrRegister  output  7  register address of the last completed write.
REQ-008 SHALL have port wrData  output  9  data of the last completed write.
REQ-009 SHALL have port busy  output  1  high from a START until the following STOP.
REQ-010 SHALL have port nackCount  output  8  saturating count of NACKed bytes.
REQ-011 SHALL have ports rdAddr (input 4) and rdData (output 9) only when I2C_RESP_REGFILE_EN is defined.

Function
REQ-012 SHALL pass SDCLK and SDAT through 2-flop synchronizers; all edge and condition detection SHALL use the synchronized copies only.
REQ-013 SHALL detect START as synchronized SDAT falling while SDCLK is high, and STOP as SDAT rising while SDCLK is high.
REQ-014 SHALL sample data bits MSB-first on detected SDCLK rising edges; it SHALL change its SDAT drive only in the cycle after a detected SDCLK falling edge.
REQ-015 SHALL implement states IDLE, ADDR, ACK_ADDR, REG, ACK_REG, DATA, ACK_DATA, WAIT_STOP.
REQ-016 IDLE -> ADDR on START; ADDR collects 8 bits: {addr[6:0], R/W}.
REQ-017 On addr == DEV_ADDR and R/W == 0: SHALL ACK (hold SDAT low for the 9th clock), then go to REG; otherwise SHALL not drive SDAT (NACK), increment nackCount, and go to WAIT_STOP.
REQ-018 REG collects byte {reg[6:0], data[8]} and ACKs it; DATA collects data[7:0] and ACKs it; then the FSM goes to WAIT_STOP.
REQ-019 SHALL assert wrValid for exactly one clk in the cycle after the SDCLK rising edge of data bit 0 is detected, with wrRegister/wrData valid in that cycle and held until the next write.
REQ-020 In WAIT_STOP, every further byte SHALL be NACKed and counted; no further wrValid.
REQ-021 STOP in any state SHALL return the FSM to IDLE, release SDAT, and discard any partial transfer without a wrValid pulse.
REQ-022 Repeated START in any non-IDLE state SHALL restart at ADDR with the bit counter cleared.
REQ-023 The ACK drive SHALL start after the SDCLK falling edge that ends bit 8 and release after the falling edge that ends the 9th clock.
REQ-024 nackCount SHALL saturate at 8'hFF and never wrap.

Reset
REQ-025 While rst == 0 at a clk edge: FSM = IDLE, SDAT = high-Z, wrValid = 0, wrRegister = 0, wrData = 0, busy = 0, nackCount = 0, synchronizers = 1'b1.
REQ-026 Reset during a transfer SHALL abort it with no wrValid; the next transfer requires a fresh START.

Configuration
REQ-027 With macro I2C_RESP_REGFILE_EN defined, the block SHALL contain a 10 x 9-bit register file (addresses 0-9), written on wrValid when wrRegister <= 9, reset to 0, readable combinationally via rdData = file[rdAddr], with rdData = 0 for rdAddr >= 10.
REQ-028 With I2C_RESP_REGFILE_EN defined, a write to wrRegister 7'd15 SHALL clear all 10 entries to 0 in the same cycle as wrValid; writes to addresses 10-14 and 16-127 SHALL be strobed but not stored.
REQ-029 Without I2C_RESP_REGFILE_EN, there SHALL be no register file and no rdAddr/rdData ports; all other behaviour is identical.

Verification
REQ-030 Write addr 0x1A/W, bytes 0x0C,0x10 -> three ACKs; one wrValid with wrRegister = 7'h06, wrData = 9'h010; busy falls at STOP.
REQ-031 Address 0x1B/W -> address byte NACKed, SDAT never driven low, nackCount = 1, no wrValid.
REQ-032 Address 0x1A/R -> NACK, nackCount increments, FSM returns to IDLE on STOP.
REQ-033 STOP after the register byte -> no wrValid; a following complete write to reg 7'h07, data 9'h013 -> wrValid with those values.
REQ-034 REGFILE_EN: write reg 4 = 9'h010, then reg 15 = 9'h000 -> rdData at rdAddr 4 reads 9'h010, then 0.
REQ-035 Pulse rst low mid-DATA byte -> all outputs at reset values, SDAT high-Z, no wrValid; the next full write succeeds.
